puf_scan_master: RTL and testbench
==================================

PUF_SCAN_MASTER -- requirements
Module: puf_scan_master

Interface
REQ-001 Parameter EVAL_CYCLES, default 16, meaning: cycles the PUF is left to evaluate between challenge load and response capture; legal 1..63.
REQ-002 Parameter RST_CYCLES, default 2, meaning: cycles puf_reset is held high at start of each transaction; legal 1..15.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset; assertion takes effect immediately, deassertion synchronous to clk.
REQ-005 start  input  1  transaction request; sampled only in IDLE.
REQ-006 challenge  input  32  challenge word; captured on accepted start.
REQ-007 length  input  2  challenge/response length code: 0=8, 1=16, 2=24, 3=32 bits; captured on accepted start.
REQ-008 puf_sel  input  2  PUF instance select; captured on accepted start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when response and resp_bit are valid.
REQ-011 response  output  32  captured scan-out bits; held until next accepted start.
REQ-012 resp_bit  output  1  sampled single-bit PUF out.
REQ-013 puf_reset  output  1  active-high reset to PUF core.
REQ-014 puf_si  output  1  serial challenge data to PUF scan-in.
REQ-015 puf_shift  output  1  scan shift enable to PUF; high only in SHIFT and CAPTURE.
REQ-016 puf_sel_o  output  2  latched puf_sel; length_o  output  2  latched length.
REQ-017 puf_so  input  1  PUF scan-out; puf_out  input  1  PUF single-bit response.

Function
REQ-018 FSM states SHALL be IDLE, RST, SHIFT, EVAL, CAPTURE, DONE; one 6-bit down-counter times all multi-cycle states.
REQ-019 In IDLE, start=1 SHALL latch challenge, length, puf_sel, clear response and resp_bit to 0, and move to RST next cycle; start while busy SHALL be ignored.
REQ-020 RST SHALL hold puf_reset=1 for exactly RST_CYCLES cycles, then enter SHIFT.
REQ-021 N SHALL be 8*(length+1) from the latched length.
REQ-022 SHIFT SHALL last exactly N cycles with puf_shift=1, driving puf_si = challenge[k] in the k-th SHIFT cycle (k=0..N-1, LSB first); challenge bits >= N are never driven.
REQ-023 Outside SHIFT, puf_si SHALL be 0.
REQ-024 EVAL SHALL last exactly EVAL_CYCLES cycles with puf_shift=0, puf_reset=0; puf_out SHALL be registered into resp_bit on the final EVAL cycle.
REQ-025 CAPTURE SHALL last exactly N cycles with puf_shift=1; puf_so sampled in the k-th CAPTURE cycle SHALL be stored to response[k]; response[31:N] SHALL remain 0.
REQ-026 DONE SHALL last one cycle with done=1, busy=1, then return to IDLE; a start in the DONE cycle is ignored.
REQ-027 Minimum transaction latency, accepted start to done, SHALL be RST_CYCLES + 2N + EVAL_CYCLES + 1 cycles.
REQ-028 puf_sel_o and length_o SHALL change only on an accepted start.
REQ-029 Changes on challenge/length/puf_sel while busy SHALL have no effect on the transaction in progress.

Reset
REQ-030 rstn=0 SHALL force IDLE and, without waiting for clk, busy=0, done=0, response=0, resp_bit=0, puf_reset=1, puf_si=0, puf_shift=0, puf_sel_o=0, length_o=0, counter=0.
REQ-031 puf_reset SHALL drop to 0 on the first clk edge after rstn deasserts in IDLE.
REQ-032 rstn asserted mid-transaction SHALL abort it; no done pulse is produced, and the next start after release runs a full transaction.

Verification
REQ-033 length=3, challenge=0xA5C3_0F96, defaults, PUF model echoes challenge on puf_so -> puf_si serial stream 0,1,1,0,1,0,0,1,... (LSB first); done at cycle 2+32+16+32+1=83 after start; response=0xA5C3_0F96.
REQ-034 length=0, challenge=0xFFFF_FF5A, echo model -> exactly 8 puf_shift cycles per phase; response=0x0000_005A; done at cycle 2+8+16+8+1=35 after start.
REQ-035 puf_out forced 1 only on the last EVAL cycle -> resp_bit=1; puf_out forced 1 on all cycles except the last EVAL cycle -> resp_bit=0.
REQ-036 start pulsed every cycle during a transaction, challenge/length toggled while busy -> single done pulse, outputs match first latched values, and puf_sel_o stays constant.
REQ-037 rstn pulsed low in the 10th SHIFT cycle -> busy=0, puf_shift=0, and puf_reset=1 asynchronously; no done pulse; the next start with length=1 completes with done 2+16+16+16+1=51 cycles after start.
REQ-038 EVAL_CYCLES=1, RST_CYCLES=1, length=2 -> done 1+24+1+24+1=51 cycles after start; puf_reset high for exactly 1 cycle.

Source files
------------

// File: rtl/puf_scan_master.sv
// ---------------------------------------------------------------------------
// puf_scan_master
//
// Sequences one transaction with a scan-chain PUF core. Each transaction:
//   RST     : hold puf_reset high for RST_CYCLES cycles
//   SHIFT   : shift N challenge bits into the PUF, LSB first (puf_shift=1)
//   EVAL    : let the PUF settle for EVAL_CYCLES cycles, then sample puf_out
//   CAPTURE : shift N response bits out of the PUF into response[N-1:0]
//   DONE    : one-cycle done pulse, then back to IDLE
// where N = 8*(length+1). Latency from accepted start to done is
// RST_CYCLES + 2N + EVAL_CYCLES + 1 cycles.
//
// Parameters
//   EVAL_CYCLES : PUF evaluation time in cycles (1..63)
//   RST_CYCLES  : puf_reset pulse width in cycles (1..15)
//
// Ports
//   clk        in   clock, all state on rising edge
//   rstn       in   asynchronous active-low reset
//   start      in   transaction request, sampled only in IDLE
//   challenge  in   32-bit challenge word, captured on accepted start
//   length     in   length code 0..3 -> 8/16/24/32 bits
//   puf_sel    in   PUF instance select, captured on accepted start
//   puf_so     in   PUF scan-out
//   puf_out    in   PUF single-bit response
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when response/resp_bit are valid
//   response   out  captured scan-out bits, held until next accepted start
//   resp_bit   out  sampled single-bit PUF response
//   puf_reset  out  active-high PUF core reset
//   puf_si     out  serial challenge data to PUF scan-in
//   puf_shift  out  PUF scan shift enable (SHIFT and CAPTURE only)
//   puf_sel_o  out  latched puf_sel
//   length_o   out  latched length
// ---------------------------------------------------------------------------
module puf_scan_master #(
  parameter int EVAL_CYCLES = 16,
  parameter int RST_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] challenge,
  input  logic [1:0]  length,
  input  logic [1:0]  puf_sel,
  input  logic        puf_so,
  input  logic        puf_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] response,
  output logic        resp_bit,
  output logic        puf_reset,
  output logic        puf_si,
  output logic        puf_shift,
  output logic [1:0]  puf_sel_o,
  output logic [1:0]  length_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_SHIFT,
    S_EVAL,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [5:0] RST_INIT  = 6'(RST_CYCLES);
  localparam logic [5:0] EVAL_INIT = 6'(EVAL_CYCLES);

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] chal_q;      // challenge, shifted right one bit per SHIFT cycle
  logic [1:0]  len_q;
  logic [1:0]  sel_q;
  logic [31:0] resp_q;
  logic        resp_bit_q;
  logic        busy_q;
  logic        done_q;
  logic        puf_reset_q;
  logic        puf_si_q;
  logic        puf_shift_q;

  logic [5:0]  nbits_d;     // N = 8*(len+1), 8..32
  logic [4:0]  cap_idx_d;   // bit index of the current CAPTURE cycle

  // The counter is loaded with N on CAPTURE entry and counts down, so the
  // k-th capture cycle sees cnt_q = N-k.
  always_comb begin
    nbits_d   = {1'b0, len_q, 3'b000} + 6'd8;
    cap_idx_d = 5'(nbits_d - cnt_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      chal_q      <= 32'd0;
      len_q       <= 2'd0;
      sel_q       <= 2'd0;
      resp_q      <= 32'd0;
      resp_bit_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      puf_reset_q <= 1'b1;
      puf_si_q    <= 1'b0;
      puf_shift_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          puf_shift_q <= 1'b0;
          puf_si_q    <= 1'b0;
          if (start) begin
            chal_q      <= challenge;
            len_q       <= length;
            sel_q       <= puf_sel;
            resp_q      <= 32'd0;
            resp_bit_q  <= 1'b0;
            busy_q      <= 1'b1;
            puf_reset_q <= 1'b1;
            cnt_q       <= RST_INIT;
            state_q     <= S_RST;
          end else begin
            // Releases the PUF reset left asserted by rstn.
            puf_reset_q <= 1'b0;
          end
        end

        S_RST: begin
          if (cnt_q == 6'd1) begin
            // Present challenge bit 0 in the first SHIFT cycle.
            puf_reset_q <= 1'b0;
            puf_shift_q <= 1'b1;
            puf_si_q    <= chal_q[0];
            chal_q      <= {1'b0, chal_q[31:1]};
            cnt_q       <= nbits_d;
            state_q     <= S_SHIFT;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end

        S_SHIFT: begin
          if (cnt_q == 6'd1) begin
            puf_shift_q <= 1'b0;
            puf_si_q    <= 1'b0;
            cnt_q       <= EVAL_INIT;
            state_q     <= S_EVAL;
          end else begin
            puf_si_q <= chal_q[0];
            chal_q   <= {1'b0, chal_q[31:1]};
            cnt_q    <= cnt_q - 6'd1;
          end
        end

        S_EVAL: begin
          if (cnt_q == 6'd1) begin
            resp_bit_q  <= puf_out;
            puf_shift_q <= 1'b1;
            cnt_q       <= nbits_d;
            state_q     <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end

        S_CAPTURE: begin
          resp_q[cap_idx_d] <= puf_so;
          if (cnt_q == 6'd1) begin
            puf_shift_q <= 1'b0;
            done_q      <= 1'b1;
            cnt_q       <= 6'd0;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          puf_shift_q <= 1'b0;
          puf_si_q    <= 1'b0;
          cnt_q       <= 6'd0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign response  = resp_q;
  assign resp_bit  = resp_bit_q;
  assign puf_reset = puf_reset_q;
  assign puf_si    = puf_si_q;
  assign puf_shift = puf_shift_q;
  assign puf_sel_o = sel_q;
  assign length_o  = len_q;

endmodule

// File: tb/tb_puf_scan_master.sv
module tb_puf_scan_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [31:0] challenge = 32'd0;
  logic [1:0]  length = 2'd0;
  logic [1:0]  puf_sel = 2'd0;
  logic        puf_so;
  logic        puf_so2 = 1'b0;
  logic        puf_out = 1'b0;

  logic        busy, done, resp_bit, puf_reset, puf_si, puf_shift;
  logic [31:0] response;
  logic [1:0]  puf_sel_o, length_o;

  logic        busy2, done2, resp_bit2, puf_reset2, puf_si2, puf_shift2;
  logic [31:0] response2;
  logic [1:0]  sel2_o, len2_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  puf_scan_master u_dut (
    .clk(clk), .rstn(rstn), .start(start), .challenge(challenge),
    .length(length), .puf_sel(puf_sel), .puf_so(puf_so), .puf_out(puf_out),
    .busy(busy), .done(done), .response(response), .resp_bit(resp_bit),
    .puf_reset(puf_reset), .puf_si(puf_si), .puf_shift(puf_shift),
    .puf_sel_o(puf_sel_o), .length_o(length_o)
  );

  puf_scan_master #(.EVAL_CYCLES(1), .RST_CYCLES(1)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .challenge(challenge),
    .length(length), .puf_sel(puf_sel), .puf_so(puf_so2), .puf_out(puf_out),
    .busy(busy2), .done(done2), .response(response2), .resp_bit(resp_bit2),
    .puf_reset(puf_reset2), .puf_si(puf_si2), .puf_shift(puf_shift2),
    .puf_sel_o(sel2_o), .length_o(len2_o)
  );

  // Echo PUF: first n_cur shifted-in bits are stored, later shift cycles
  // read them back out in the same order.
  logic [31:0] mem_m;
  int wr_m, rd_m, sc_m;
  int n_cur = 8;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_m <= 0; rd_m <= 0; sc_m <= 0;
    end else if (puf_reset) begin
      wr_m <= 0; rd_m <= 0; sc_m <= 0;
    end else if (puf_shift) begin
      if (sc_m < n_cur) begin
        mem_m[wr_m[4:0]] <= puf_si;
        wr_m <= wr_m + 1;
      end else begin
        rd_m <= rd_m + 1;
      end
      sc_m <= sc_m + 1;
    end
  end

  assign puf_so = (rd_m < wr_m) ? mem_m[rd_m[4:0]] : 1'b0;

  // Observations from the last transaction.
  int          lat, n_sh, n_cap, n_rst, n_done, busy_drop, last_eval;
  logic [31:0] si_w;
  logic        seen_eval, sel_changed;
  logic        ab_busy, ab_shift, ab_rst, aborted;
  logic [31:0] r1_resp;
  logic        r1_bit;

  task automatic run_txn(input logic [31:0] ch, input logic [1:0] ln,
                         input logic [1:0] sel, input int pmode,
                         input bit tog, input int abort_sh);
    n_cur = 8 * (int'(ln) + 1);
    last_eval = 2 + n_cur + 16;
    lat = 0; n_sh = 0; n_cap = 0; n_rst = 0; n_done = 0; busy_drop = 0;
    si_w = 32'd0; seen_eval = 1'b0; sel_changed = 1'b0; aborted = 1'b0;
    ab_busy = 1'b1; ab_shift = 1'b1; ab_rst = 1'b0;
    r1_resp = 32'hFFFF_FFFF; r1_bit = 1'b1;
    @(negedge clk);
    challenge = ch; length = ln; puf_sel = sel; start = 1'b1;
    puf_out = (pmode == 2);
    @(posedge clk);
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (tog) begin
        start = 1'b1;
        challenge = ~challenge;
        length = length + 2'd1;
        puf_sel = puf_sel + 2'd1;
      end else begin
        start = 1'b0;
      end
      if (pmode == 1)      puf_out = (lat == last_eval);
      else if (pmode == 2) puf_out = (lat != last_eval);
      else                 puf_out = 1'b0;
      if (lat == 1) begin r1_resp = response; r1_bit = resp_bit; end
      if (puf_sel_o != sel) sel_changed = 1'b1;
      if (puf_reset) n_rst++;
      if (!busy) busy_drop++;
      if (puf_shift) begin
        if (!seen_eval) begin
          if (n_sh < 32) si_w[n_sh] = puf_si;
          n_sh++;
        end else begin
          n_cap++;
        end
      end else if (n_sh > 0) begin
        seen_eval = 1'b1;
      end
      if (abort_sh != 0 && n_sh == abort_sh && !seen_eval) begin
        rstn = 1'b0;
        #1;
        ab_busy = busy; ab_shift = puf_shift; ab_rst = puf_reset;
        #2;
        rstn = 1'b1;
        start = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (done) begin
        n_done++;
        start = 1'b0;
        break;
      end
    end
    puf_out = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (response !== 32'd0 || resp_bit !== 1'b0) begin bad++; $display("FAIL rst_resp got=%h/%b want=0/0", response, resp_bit); end
    total++; if (puf_reset !== 1'b1) begin bad++; $display("FAIL rst_pufreset got=%b want=1", puf_reset); end
    total++; if (puf_si !== 1'b0 || puf_shift !== 1'b0) begin bad++; $display("FAIL rst_scan got=%b%b want=00", puf_si, puf_shift); end
    total++; if (puf_sel_o !== 2'd0 || length_o !== 2'd0) begin bad++; $display("FAIL rst_latch got=%0d/%0d want=0/0", puf_sel_o, length_o); end
    repeat (2) @(negedge clk);
    total++; if (puf_reset !== 1'b1) begin bad++; $display("FAIL rst_hold got=%b want=1", puf_reset); end
    rstn = 1'b1;
    @(negedge clk);
    total++; if (puf_reset !== 1'b0) begin bad++; $display("FAIL rst_release got=%b want=0", puf_reset); end
  endtask

  task automatic test_len32();
    run_txn(32'hA5C3_0F96, 2'd3, 2'd2, 0, 1'b0, 0);
    total++; if (lat !== 83) begin bad++; $display("FAIL len32_lat got=%0d want=83", lat); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL len32_done got=%0d want=1", n_done); end
    total++; if (si_w[7:0] !== 8'b1001_0110) begin bad++; $display("FAIL len32_si8 got=%b want=10010110", si_w[7:0]); end
    total++; if (si_w !== 32'hA5C3_0F96) begin bad++; $display("FAIL len32_si got=%h want=a5c30f96", si_w); end
    total++; if (n_sh !== 32 || n_cap !== 32) begin bad++; $display("FAIL len32_shifts got=%0d/%0d want=32/32", n_sh, n_cap); end
    total++; if (n_rst !== 2) begin bad++; $display("FAIL len32_rstw got=%0d want=2", n_rst); end
    total++; if (response !== 32'hA5C3_0F96) begin bad++; $display("FAIL len32_resp got=%h want=a5c30f96", response); end
    total++; if (busy_drop !== 0) begin bad++; $display("FAIL len32_busy got=%0d want=0", busy_drop); end
    total++; if (puf_sel_o !== 2'd2 || length_o !== 2'd3) begin bad++; $display("FAIL len32_latch got=%0d/%0d want=2/3", puf_sel_o, length_o); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL len32_idle got=%b%b want=00", busy, done); end
    total++; if (response !== 32'hA5C3_0F96) begin bad++; $display("FAIL len32_hold got=%h want=a5c30f96", response); end
  endtask

  task automatic test_len8();
    run_txn(32'hFFFF_FF5A, 2'd0, 2'd1, 0, 1'b0, 0);
    total++; if (lat !== 35) begin bad++; $display("FAIL len8_lat got=%0d want=35", lat); end
    total++; if (n_sh !== 8 || n_cap !== 8) begin bad++; $display("FAIL len8_shifts got=%0d/%0d want=8/8", n_sh, n_cap); end
    total++; if (si_w !== 32'h0000_005A) begin bad++; $display("FAIL len8_si got=%h want=0000005a", si_w); end
    total++; if (response !== 32'h0000_005A) begin bad++; $display("FAIL len8_resp got=%h want=0000005a", response); end
    total++; if (r1_resp !== 32'd0) begin bad++; $display("FAIL len8_clear got=%h want=0", r1_resp); end
  endtask

  task automatic test_resp_bit();
    run_txn(32'h0000_003C, 2'd0, 2'd0, 1, 1'b0, 0);
    total++; if (resp_bit !== 1'b1) begin bad++; $display("FAIL rbit_last got=%b want=1", resp_bit); end
    total++; if (response !== 32'h0000_003C) begin bad++; $display("FAIL rbit_resp got=%h want=0000003c", response); end
    run_txn(32'h0000_00C3, 2'd0, 2'd0, 2, 1'b0, 0);
    total++; if (r1_bit !== 1'b0) begin bad++; $display("FAIL rbit_clear got=%b want=0", r1_bit); end
    total++; if (resp_bit !== 1'b0) begin bad++; $display("FAIL rbit_notlast got=%b want=0", resp_bit); end
  endtask

  task automatic test_back_to_back();
    int extra;
    run_txn(32'h1234_ABCD, 2'd1, 2'd3, 0, 1'b1, 0);
    total++; if (lat !== 51) begin bad++; $display("FAIL b2b_lat got=%0d want=51", lat); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL b2b_done got=%0d want=1", n_done); end
    total++; if (si_w !== 32'h0000_ABCD) begin bad++; $display("FAIL b2b_si got=%h want=0000abcd", si_w); end
    total++; if (response !== 32'h0000_ABCD) begin bad++; $display("FAIL b2b_resp got=%h want=0000abcd", response); end
    total++; if (sel_changed !== 1'b0) begin bad++; $display("FAIL b2b_sel got=%b want=0", sel_changed); end
    total++; if (length_o !== 2'd1 || puf_sel_o !== 2'd3) begin bad++; $display("FAIL b2b_latch got=%0d/%0d want=1/3", length_o, puf_sel_o); end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL b2b_extra got=%0d want=0", extra); end
  endtask

  task automatic test_abort();
    int dn;
    run_txn(32'hF0F0_F0F0, 2'd3, 2'd1, 0, 1'b0, 10);
    total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_hit got=%b want=1", aborted); end
    total++; if (ab_busy !== 1'b0 || ab_shift !== 1'b0) begin bad++; $display("FAIL abort_async got=%b%b want=00", ab_busy, ab_shift); end
    total++; if (ab_rst !== 1'b1) begin bad++; $display("FAIL abort_pufrst got=%b want=1", ab_rst); end
    @(negedge clk);
    total++; if (puf_reset !== 1'b0) begin bad++; $display("FAIL abort_release got=%b want=0", puf_reset); end
    total++; if (length_o !== 2'd0 || puf_sel_o !== 2'd0) begin bad++; $display("FAIL abort_latch got=%0d/%0d want=0/0", length_o, puf_sel_o); end
    dn = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) dn++;
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL abort_nodone got=%0d want=0", dn); end
    run_txn(32'h5555_BEEF, 2'd1, 2'd2, 0, 1'b0, 0);
    total++; if (lat !== 51) begin bad++; $display("FAIL abort_next_lat got=%0d want=51", lat); end
    total++; if (response !== 32'h0000_BEEF) begin bad++; $display("FAIL abort_next_resp got=%h want=0000beef", response); end
  endtask

  task automatic test_short_params();
    int lat2, rst2, sh2, ones2, dn2;
    lat2 = 0; rst2 = 0; sh2 = 0; ones2 = 0; dn2 = 0;
    @(negedge clk);
    challenge = 32'h00FF_FFFF; length = 2'd2; puf_sel = 2'd1; start2 = 1'b1;
    @(posedge clk);
    while (lat2 < 300) begin
      @(negedge clk);
      start2 = 1'b0;
      lat2++;
      if (puf_reset2) rst2++;
      if (puf_shift2) sh2++;
      if (puf_si2) ones2++;
      if (done2) begin dn2++; break; end
    end
    total++; if (lat2 !== 51) begin bad++; $display("FAIL short_lat got=%0d want=51", lat2); end
    total++; if (rst2 !== 1) begin bad++; $display("FAIL short_rstw got=%0d want=1", rst2); end
    total++; if (sh2 !== 48 || ones2 !== 24) begin bad++; $display("FAIL short_shift got=%0d/%0d want=48/24", sh2, ones2); end
    total++; if (response2 !== 32'd0 || resp_bit2 !== 1'b0) begin bad++; $display("FAIL short_resp got=%h/%b want=0/0", response2, resp_bit2); end
    total++; if (len2_o !== 2'd2 || sel2_o !== 2'd1) begin bad++; $display("FAIL short_latch got=%0d/%0d want=2/1", len2_o, sel2_o); end
    @(negedge clk);
    total++; if (busy2 !== 1'b0 || done2 !== 1'b0 || dn2 !== 1) begin bad++; $display("FAIL short_idle got=%b%b/%0d want=00/1", busy2, done2, dn2); end
  endtask

  initial begin
    test_reset();
    test_len32();
    test_len8();
    test_resp_bit();
    test_back_to_back();
    test_abort();
    test_short_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
